// File: rtl/projectile_pkg.sv
// rtl/projectile_pkg.sv - shared types and defaults for the projectile pool
package projectile_pkg;

    localparam int N_SLOTS_DEF  = 4;
    localparam int SPEED_DEF    = 4;
    localparam int COOLDOWN_DEF = 8;
    localparam int OBJ_W_DEF    = 32;
    localparam int OBJ_H_DEF    = 32;
    localparam int COORD_W      = 11;

    typedef struct packed {
        logic               active;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } slot_t;

    typedef enum logic {
        IDLE   = 1'b0,
        UPDATE = 1'b1
    } state_t;

    // Coverage test done in 12 bits so x+w near the right/bottom edge cannot wrap
    function automatic logic slot_covers(input slot_t s,
                                         input logic [COORD_W-1:0] px,
                                         input logic [COORD_W-1:0] py,
                                         input int w,
                                         input int h);
        logic [COORD_W:0] x_end;
        logic [COORD_W:0] y_end;
        x_end = {1'b0, s.x} + (COORD_W+1)'(w);
        y_end = {1'b0, s.y} + (COORD_W+1)'(h);
        return s.active &&
               (px >= s.x) && ({1'b0, px} < x_end) &&
               (py >= s.y) && ({1'b0, py} < y_end);
    endfunction

endpackage

// File: rtl/projectile_hit_select.sv
// rtl/projectile_hit_select.sv - registered per-pixel slot arbitration and offset generation
module projectile_hit_select
    import projectile_pkg::*;
#(
    parameter int N_SLOTS = N_SLOTS_DEF,
    parameter int OBJ_W   = OBJ_W_DEF,
    parameter int OBJ_H   = OBJ_H_DEF
) (
    input  logic                       clk,
    input  logic                       resetN,
    input  slot_t                      slots [N_SLOTS],
    input  logic [COORD_W-1:0]         pixelX,
    input  logic [COORD_W-1:0]         pixelY,
    output logic                       insideRect,
    output logic [COORD_W-1:0]         offsetX,
    output logic [COORD_W-1:0]         offsetY,
    output logic [$clog2(N_SLOTS)-1:0] sel_idx
);

    localparam int IDX_W = $clog2(N_SLOTS);

    logic               hit_found;
    logic [IDX_W-1:0]   hit_win;
    logic [COORD_W-1:0] off_x;
    logic [COORD_W-1:0] off_y;

    // Priority encode: scan from the top so the lowest covering index wins
    always_comb begin
        hit_found = 1'b0;
        hit_win   = '0;
        for (int i = N_SLOTS - 1; i >= 0; i--) begin
            if (slot_covers(slots[i], pixelX, pixelY, OBJ_W, OBJ_H)) begin
                hit_found = 1'b1;
                hit_win   = IDX_W'(i);
            end
        end
        off_x = pixelX - slots[hit_win].x;
        off_y = pixelY - slots[hit_win].y;
    end

    // One-cycle pipeline toward the bitmap reader; no winner drives all zeros
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            insideRect <= 1'b0;
            sel_idx    <= '0;
            offsetX    <= '0;
            offsetY    <= '0;
        end else if (hit_found) begin
            insideRect <= 1'b1;
            sel_idx    <= hit_win;
            offsetX    <= off_x;
            offsetY    <= off_y;
        end else begin
            insideRect <= 1'b0;
            sel_idx    <= '0;
            offsetX    <= '0;
            offsetY    <= '0;
        end
    end

endmodule

// File: rtl/projectile_pool_ctrl.sv
// rtl/projectile_pool_ctrl.sv - projectile slot pool: allocation, per-frame motion, retirement, draw arbitration
module projectile_pool_ctrl
    import projectile_pkg::*;
#(
    parameter int N_SLOTS         = N_SLOTS_DEF,
    parameter int SPEED           = SPEED_DEF,
    parameter int COOLDOWN_FRAMES = COOLDOWN_DEF,
    parameter int OBJ_W           = OBJ_W_DEF,
    parameter int OBJ_H           = OBJ_H_DEF
) (
    input  logic                       clk,
    input  logic                       resetN,
    input  logic                       startOfFrame,
    input  logic                       fire_req,
    input  logic [10:0]                fire_x,
    input  logic [10:0]                fire_y,
    output logic                       fire_ack,
    output logic                       pool_full,
    input  logic                       hit_valid,
    input  logic [$clog2(N_SLOTS)-1:0] hit_idx,
    input  logic [10:0]                pixelX,
    input  logic [10:0]                pixelY,
    output logic                       insideRect,
    output logic [10:0]                offsetX,
    output logic [10:0]                offsetY,
    output logic [$clog2(N_SLOTS)-1:0] sel_idx,
    output logic [N_SLOTS-1:0]         active_mask
);

    localparam int IDX_W = $clog2(N_SLOTS);

    state_t           state_q;
    state_t           state_d;
    logic [IDX_W-1:0] slot_cnt_q;
    slot_t            slots_q [N_SLOTS];
    slot_t            slots_d [N_SLOTS];
    logic [7:0]       cooldown_q;
    logic             upd_en;
    logic             fire_go;
    logic             free_found;
    logic [IDX_W-1:0] free_idx;
    logic             all_active_d;

    // State register
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next state: a frame pulse starts a sweep, the sweep ends after the last slot
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (startOfFrame) state_d = UPDATE;
            UPDATE:  if (slot_cnt_q == IDX_W'(N_SLOTS - 1)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs; the !fire_ack term keeps a held request from double-firing even with zero cooldown
    always_comb begin
        upd_en  = (state_q == UPDATE);
        fire_go = (state_q == IDLE) && fire_req && (cooldown_q == 8'd0) &&
                  free_found && !fire_ack;
    end

    // Sweep index: counts only while updating, parked at zero otherwise
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN)     slot_cnt_q <= '0;
        else if (upd_en) slot_cnt_q <= slot_cnt_q + IDX_W'(1);
        else             slot_cnt_q <= '0;
    end

    // Lowest-index free slot
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = N_SLOTS - 1; i >= 0; i--) begin
            if (!slots_q[i].active) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    // Slot next-state: motion, then hit (overrides motion), then allocation (overrides a stale hit)
    always_comb begin
        for (int i = 0; i < N_SLOTS; i++) slots_d[i] = slots_q[i];
        if (upd_en && slots_q[slot_cnt_q].active) begin
            if (slots_q[slot_cnt_q].y < 11'(SPEED))
                slots_d[slot_cnt_q].active = 1'b0;
            else
                slots_d[slot_cnt_q].y = slots_q[slot_cnt_q].y - 11'(SPEED);
        end
        if (hit_valid) slots_d[hit_idx].active = 1'b0;
        if (fire_go) begin
            slots_d[free_idx].active = 1'b1;
            slots_d[free_idx].x      = fire_x;
            slots_d[free_idx].y      = fire_y;
        end
    end

    // Pool-full flag derived from the slot state being written this edge
    always_comb begin
        all_active_d = 1'b1;
        for (int i = 0; i < N_SLOTS; i++) all_active_d = all_active_d & slots_d[i].active;
    end

    // Slot storage and pool-full register
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < N_SLOTS; i++) slots_q[i] <= '0;
            pool_full <= 1'b0;
        end else begin
            for (int i = 0; i < N_SLOTS; i++) slots_q[i] <= slots_d[i];
            pool_full <= all_active_d;
        end
    end

    // Cooldown: reload on an accepted shot, otherwise count down frame pulses
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN)                                cooldown_q <= 8'd0;
        else if (fire_go)                           cooldown_q <= 8'(COOLDOWN_FRAMES);
        else if (startOfFrame && cooldown_q != 8'd0) cooldown_q <= cooldown_q - 8'd1;
    end

    // Acknowledge pulse, aligned with the slot becoming active
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) fire_ack <= 1'b0;
        else         fire_ack <= fire_go;
    end

    // Live-slot view straight from the slot registers
    always_comb begin
        for (int i = 0; i < N_SLOTS; i++) active_mask[i] = slots_q[i].active;
    end

    projectile_hit_select #(
        .N_SLOTS (N_SLOTS),
        .OBJ_W   (OBJ_W),
        .OBJ_H   (OBJ_H)
    ) u_hit_select (
        .clk        (clk),
        .resetN     (resetN),
        .slots      (slots_q),
        .pixelX     (pixelX),
        .pixelY     (pixelY),
        .insideRect (insideRect),
        .offsetX    (offsetX),
        .offsetY    (offsetY),
        .sel_idx    (sel_idx)
    );

endmodule

// File: tb/tb_projectile_pool_ctrl.sv
// tb/tb_projectile_pool_ctrl.sv - self-checking bench for projectile_pool_ctrl
module tb_projectile_pool_ctrl;

    localparam int N  = 4;
    localparam int SP = 4;
    localparam int CD = 8;
    localparam int W  = 32;
    localparam int H  = 32;

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic        startOfFrame = 1'b0;
    logic        fire_req = 1'b0;
    logic [10:0] fire_x = '0;
    logic [10:0] fire_y = '0;
    logic        fire_ack;
    logic        pool_full;
    logic        hit_valid = 1'b0;
    logic [1:0]  hit_idx = '0;
    logic [10:0] pixelX = '0;
    logic [10:0] pixelY = '0;
    logic        insideRect;
    logic [10:0] offsetX;
    logic [10:0] offsetY;
    logic [1:0]  sel_idx;
    logic [3:0]  active_mask;

    projectile_pool_ctrl #(
        .N_SLOTS(N), .SPEED(SP), .COOLDOWN_FRAMES(CD), .OBJ_W(W), .OBJ_H(H)
    ) dut (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
        .fire_req(fire_req), .fire_x(fire_x), .fire_y(fire_y),
        .fire_ack(fire_ack), .pool_full(pool_full),
        .hit_valid(hit_valid), .hit_idx(hit_idx),
        .pixelX(pixelX), .pixelY(pixelY),
        .insideRect(insideRect), .offsetX(offsetX), .offsetY(offsetY),
        .sel_idx(sel_idx), .active_mask(active_mask)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Reference model: slot arrays, cooldown, and the cycle number where the current sweep began
    int m_act [N];
    int m_x [N];
    int m_y [N];
    int m_cd;
    int m_upd_start;
    int cyc = 0;
    int e_ack, e_full, e_mask, e_in, e_sel, e_ox, e_oy;

    typedef struct {
        int grp;
        int px;
        int py;
        int in_e;
        int sel_e;
        int ox_e;
        int oy_e;
    } probe_t;

    probe_t probes [24];
    int     n_probes;

    task automatic check_val(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    function automatic logic [31:0] dut_vec();
        return 32'({fire_ack, pool_full, active_mask, insideRect, sel_idx, offsetX, offsetY});
    endfunction

    function automatic logic [31:0] exp_vec();
        return 32'({e_ack[0], e_full[0], 4'(e_mask), e_in[0], 2'(e_sel), 11'(e_ox), 11'(e_oy)});
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_act[i] = 0; m_x[i] = 0; m_y[i] = 0;
        end
        m_cd = 0;
        m_upd_start = -1000;
        e_ack = 0; e_full = 0; e_mask = 0; e_in = 0; e_sel = 0; e_ox = 0; e_oy = 0;
    endtask

    // Applies the rules for one clock edge to the model using the currently driven inputs
    task automatic model_edge();
        int win, fidx, k, busy;
        win = -1;
        for (int i = N - 1; i >= 0; i--)
            if (m_act[i] != 0 && int'(pixelX) >= m_x[i] && int'(pixelX) < m_x[i] + W &&
                int'(pixelY) >= m_y[i] && int'(pixelY) < m_y[i] + H) win = i;
        e_in  = (win >= 0) ? 1 : 0;
        e_sel = (win >= 0) ? win : 0;
        e_ox  = (win >= 0) ? int'(pixelX) - m_x[win] : 0;
        e_oy  = (win >= 0) ? int'(pixelY) - m_y[win] : 0;
        busy  = (cyc >= m_upd_start && cyc < m_upd_start + N) ? 1 : 0;
        fidx  = -1;
        for (int i = N - 1; i >= 0; i--) if (m_act[i] == 0) fidx = i;
        e_ack = (busy == 0 && fire_req && m_cd == 0 && fidx >= 0) ? 1 : 0;
        if (busy != 0) begin
            k = cyc - m_upd_start;
            if (m_act[k] != 0) begin
                if (m_y[k] < SP) m_act[k] = 0;
                else             m_y[k] = m_y[k] - SP;
            end
        end
        if (hit_valid) m_act[hit_idx] = 0;
        if (e_ack != 0) begin
            m_act[fidx] = 1; m_x[fidx] = int'(fire_x); m_y[fidx] = int'(fire_y);
        end
        if (e_ack != 0)                m_cd = CD;
        else if (startOfFrame && m_cd > 0) m_cd = m_cd - 1;
        if (busy == 0 && startOfFrame) m_upd_start = cyc + 1;
        e_mask = 0;
        e_full = 1;
        for (int i = 0; i < N; i++) begin
            if (m_act[i] != 0) e_mask = e_mask | (1 << i);
            else               e_full = 0;
        end
        cyc++;
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check_val("step_outputs", dut_vec(), exp_vec());
    endtask

    task automatic do_reset();
        #1;
        resetN = 1'b0;
        model_reset();
        #1;
        check_val("reset_outputs", dut_vec(), 32'd0);
        @(negedge clk);
        resetN = 1'b1;
    endtask

    task automatic frame();
        startOfFrame = 1'b1;
        step();
        startOfFrame = 1'b0;
        repeat (N + 1) step();
    endtask

    task automatic fire_wait(input int x, input int y, input int max_frames, output int nsof, output int got);
        fire_x = 11'(x); fire_y = 11'(y); fire_req = 1'b1;
        nsof = 0; got = 0;
        step();
        if (fire_ack) got = 1;
        while (got == 0 && nsof < max_frames) begin
            startOfFrame = 1'b1;
            step();
            startOfFrame = 1'b0;
            nsof++;
            if (fire_ack) got = 1;
            for (int s = 0; s < N + 1 && got == 0; s++) begin
                step();
                if (fire_ack) got = 1;
            end
        end
        fire_req = 1'b0;
    endtask

    task automatic run_probes(input int grp);
        for (int i = 0; i < n_probes; i++) begin
            if (probes[i].grp == grp) begin
                pixelX = 11'(probes[i].px);
                pixelY = 11'(probes[i].py);
                step();
                check_val($sformatf("probe%0d", i),
                          32'({insideRect, sel_idx, offsetX, offsetY}),
                          32'({probes[i].in_e[0], 2'(probes[i].sel_e), 11'(probes[i].ox_e), 11'(probes[i].oy_e)}));
            end
        end
        pixelX = '0;
        pixelY = '0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int nsof, got, r, px, py;

        n_probes = 0;
        probes[n_probes++] = '{1, 100, 188, 1, 0, 0, 0};
        probes[n_probes++] = '{1, 131, 219, 1, 0, 31, 31};
        probes[n_probes++] = '{1, 100, 187, 0, 0, 0, 0};
        probes[n_probes++] = '{1, 132, 188, 0, 0, 0, 0};
        probes[n_probes++] = '{1, 99, 200, 0, 0, 0, 0};
        probes[n_probes++] = '{2, 65, 60, 1, 0, 15, 10};
        probes[n_probes++] = '{2, 90, 60, 1, 2, 30, 10};
        probes[n_probes++] = '{2, 49, 60, 0, 0, 0, 0};
        probes[n_probes++] = '{2, 81, 60, 1, 0, 31, 10};
        probes[n_probes++] = '{2, 82, 60, 1, 2, 22, 10};
        probes[n_probes++] = '{2, 60, 82, 0, 0, 0, 0};
        probes[n_probes++] = '{2, 60, 81, 1, 0, 10, 31};
        probes[n_probes++] = '{2, 91, 60, 1, 2, 31, 10};
        probes[n_probes++] = '{2, 92, 60, 0, 0, 0, 0};
        probes[n_probes++] = '{2, 510, 470, 1, 1, 10, 2};
        probes[n_probes++] = '{3, 300, 0, 1, 0, 0, 0};
        probes[n_probes++] = '{3, 331, 31, 1, 0, 31, 31};
        probes[n_probes++] = '{3, 332, 0, 0, 0, 0, 0};
        probes[n_probes++] = '{4, 700, 600, 1, 1, 0, 0};
        probes[n_probes++] = '{4, 731, 631, 1, 1, 31, 31};

        model_reset();
        repeat (2) @(posedge clk);
        do_reset();

        // First shot, then three frames of motion
        fire_wait(100, 200, 0, nsof, got);
        check_val("first_ack", 32'(got), 32'd1);
        check_val("first_mask", 32'(active_mask), 32'h1);
        repeat (3) frame();
        run_probes(1);

        // Fill the pool with cooldown gaps, arrange overlapping slots 0 and 2
        do_reset();
        fire_wait(50, 114, 0, nsof, got);
        check_val("fill0_ack", 32'(got), 32'd1);
        fire_wait(500, 500, 12, nsof, got);
        check_val("fill1_frames", 32'(nsof), 32'd8);
        check_val("fill1_ack", 32'(got), 32'd1);
        fire_wait(60, 50, 12, nsof, got);
        check_val("fill2_frames", 32'(nsof), 32'd8);
        run_probes(2);
        fire_wait(900, 900, 12, nsof, got);
        check_val("fill3_ack", 32'(got), 32'd1);
        check_val("full_mask", 32'({pool_full, active_mask}), 32'h1F);
        fire_wait(1200, 100, 3, nsof, got);
        check_val("full_no_ack", 32'(got), 32'd0);
        fire_wait(1200, 100, 8, nsof, got);
        check_val("refill_frames", 32'(nsof), 32'd5);
        check_val("refill_mask", 32'({pool_full, active_mask}), 32'h0B);

        // Retirement at the top edge
        do_reset();
        fire_wait(300, 3, 0, nsof, got);
        frame();
        check_val("retire_y3", 32'(active_mask), 32'h0);
        fire_wait(300, 4, 10, nsof, got);
        check_val("y4_frames", 32'(nsof), 32'd7);
        frame();
        check_val("y4_alive", 32'(active_mask), 32'h1);
        run_probes(3);
        frame();
        check_val("y0_retired", 32'(active_mask), 32'h0);

        // Hit on the slot being swept, with a fire request during the sweep
        do_reset();
        fire_wait(10, 400, 0, nsof, got);
        fire_wait(20, 400, 10, nsof, got);
        check_val("hit_setup_mask", 32'(active_mask), 32'h3);
        repeat (7) frame();
        startOfFrame = 1'b1;
        step();
        startOfFrame = 1'b0;
        step();
        hit_valid = 1'b1; hit_idx = 2'd1;
        fire_req = 1'b1; fire_x = 11'd700; fire_y = 11'd600;
        step();
        check_val("hit_upd_mask", 32'({fire_ack, active_mask}), 32'h01);
        hit_valid = 1'b0;
        step();
        check_val("upd_no_ack2", 32'(fire_ack), 32'd0);
        step();
        check_val("upd_no_ack3", 32'(fire_ack), 32'd0);
        step();
        check_val("idle_ack", 32'({fire_ack, active_mask}), 32'h13);
        fire_req = 1'b0;
        run_probes(4);

        // Reset in the middle of a sweep with three live slots
        fire_wait(1000, 800, 10, nsof, got);
        check_val("three_mask", 32'(active_mask), 32'h7);
        startOfFrame = 1'b1;
        step();
        startOfFrame = 1'b0;
        step();
        step();
        #1;
        resetN = 1'b0;
        model_reset();
        #1;
        check_val("midupd_reset", dut_vec(), 32'd0);
        fire_req = 1'b1; fire_x = 11'd5; fire_y = 11'd500;
        @(negedge clk);
        resetN = 1'b1;
        step();
        check_val("post_reset_ack", 32'({fire_ack, active_mask}), 32'h11);
        fire_req = 1'b0;

        // Randomized traffic against the model
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            startOfFrame = ($urandom_range(0, 7) == 0);
            fire_req     = 1'($urandom_range(0, 1));
            fire_x = ($urandom_range(0, 3) == 0) ? 11'($urandom_range(1990, 2047)) : 11'($urandom_range(0, 200));
            fire_y = ($urandom_range(0, 7) == 0) ? 11'($urandom_range(1990, 2047)) : 11'($urandom_range(0, 120));
            hit_valid = ($urandom_range(0, 9) == 0);
            hit_idx   = 2'($urandom_range(0, N - 1));
            r  = $urandom_range(0, N - 1);
            px = m_x[r] + $urandom_range(0, 40);
            py = m_y[r] + $urandom_range(0, 40);
            if (px >= 4) px = px - 4;
            if (py >= 4) py = py - 4;
            if (px > 2047) px = 2047;
            if (py > 2047) py = 2047;
            if ($urandom_range(0, 7) == 0) begin
                px = $urandom_range(0, 2047);
                py = $urandom_range(0, 2047);
            end
            pixelX = 11'(px);
            pixelY = 11'(py);
            if ($urandom_range(0, 599) == 0) do_reset();
            else                             step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/projectile_pool_ctrl.md
Name: projectile_pool_ctrl

Overview:
- Owns a fixed pool of projectile slots. Allocates a slot on a fire request, advances every live slot once per frame, and retires slots that leave the screen or are hit.
- Per pixel, arbitrates between slots and drives one shared projectileDraw instance (offsetX/offsetY/InsideRectangle).
- Sits between the player/collision logic and the projectile drawing path.

Parameters:
- N_SLOTS, 4, number of projectile slots (power of 2, 2..8).
- SPEED, 4, pixels moved upward per frame.
- COOLDOWN_FRAMES, 8, frames after an accepted shot during which fire_req is not acknowledged.
- OBJ_W, 32, projectile width in pixels (matches the 32x32 bitmap).
- OBJ_H, 32, projectile height in pixels.

Ports:
- clk  in  1  system clock
- resetN  in  1  asynchronous, active-low reset
- startOfFrame  in  1  one-cycle pulse per frame
- fire_req  in  1  level request; held until fire_ack
- fire_x  in  11  spawn top-left X, sampled with fire_ack
- fire_y  in  11  spawn top-left Y, sampled with fire_ack
- fire_ack  out  1  one-cycle pulse: request accepted, slot allocated
- pool_full  out  1  all slots active (registered)
- hit_valid  in  1  one-cycle collision pulse
- hit_idx  in  $clog2(N_SLOTS)  slot that collided
- pixelX  in  11  current scan pixel X
- pixelY  in  11  current scan pixel Y
- insideRect  out  1  some active slot covers the pixel (to InsideRectangle)
- offsetX  out  11  pixelX minus winning slot X
- offsetY  out  11  pixelY minus winning slot Y
- sel_idx  out  $clog2(N_SLOTS)  winning slot index (for collision reporting)
- active_mask  out  N_SLOTS  live slots

Behaviour:
- Reset: all slots inactive, positions 0, cooldown 0, FSM=IDLE. Every output 0.
- FSM states: IDLE, UPDATE.
  - IDLE -> UPDATE on startOfFrame. Slot counter resets to 0.
  - UPDATE processes one slot per cycle, index 0..N_SLOTS-1, then returns to IDLE. Duration is N_SLOTS cycles.
  - startOfFrame received during UPDATE is ignored.
- Slot update (active slot only):
  - If y < SPEED, the slot is deactivated (left the top edge).
  - Otherwise y <= y - SPEED. X is unchanged.
  - Arithmetic is unsigned 11-bit. No wrap is ever allowed.
- Cooldown: an 8-bit counter.
  - Loaded with COOLDOWN_FRAMES on fire_ack.
  - Decremented on each startOfFrame while non-zero.
- Fire handshake (evaluated only in IDLE):
  - fire_ack is asserted for 1 cycle when fire_req=1, cooldown=0, and at least one slot is free.
  - The lowest-index free slot is allocated, with position (fire_x, fire_y), and set active the following cycle.
  - If the pool is full, in cooldown, or the FSM is in UPDATE, there is no ack. The requester keeps fire_req high.
  - fire_ack never occurs on two consecutive cycles, because cooldown is loaded at ack.
- Collision: on hit_valid, slot hit_idx is deactivated in the same clock edge, in any FSM state.
  - hit on an inactive slot: no effect.
  - hit_valid and the UPDATE of the same slot in the same cycle: deactivation wins.
  - hit_valid and allocation of the same slot in the same cycle: allocation wins, because the hit refers to the old occupant and that slot was already free.
- Pixel arbitration, registered with 1-cycle latency from pixelX/pixelY:
  - A slot covers the pixel when it is active, x <= pixelX < x+OBJ_W, and y <= pixelY < y+OBJ_H.
  - The lowest covering index wins.
  - insideRect=1, sel_idx=winner, offsetX/offsetY = pixel minus the winner's top-left, so both are in 0..31.
  - With no winner: insideRect=0, sel_idx=0, offsets=0.
  - projectileDraw adds its own register. Total pixel-to-RGB latency is 2 cycles; the downstream mux aligns to this.
- active_mask and pool_full are registered and reflect the slot state after each edge.
- Reset mid-UPDATE or mid-handshake: immediate return to the reset state. A pending fire_req is re-evaluated after reset.

Decomposition:
- projectile_pkg holds:
  - N_SLOTS, OBJ_W, OBJ_H, and SPEED defaults
  - slot_t struct {logic active; logic [10:0] x, y;}
  - state enum {IDLE, UPDATE}
- Sub-module projectile_hit_select: registered priority encoder and offset subtractor over the slot_t array. This is the pixel-arbitration path, so it can be verified standalone.

Test Plan:
- Reset, then fire_req=1 with (100,200) -> fire_ack on the 2nd cycle, slot0 active, active_mask=0001. After 3 startOfFrame pulses, slot0 y=188.
- Fire 4 times, waiting out the 8-frame cooldown between shots -> active_mask=1111 and pool_full=1. A 5th fire_req gets no ack until a slot frees.
- Slot at y=3, then startOfFrame -> slot retires during UPDATE and its active_mask bit clears. Slot at y=4 -> y=0 and stays active.
- Slots 0 and 2 overlapping at (50,50) and (60,50), pixel (65,60) -> one cycle later insideRect=1, sel_idx=0, offsetX=15, offsetY=10. Pixel (90,60) -> sel_idx=2, offsetX=30.
- hit_valid with hit_idx=1 in the same cycle that UPDATE processes slot1 -> slot1 inactive afterwards. fire_req in that same cycle is not acked during UPDATE and is acked in the first IDLE cycle, into slot1.
- Assert resetN=0 mid-UPDATE with 3 slots active -> active_mask=0, every output 0, FSM=IDLE.
